fetch_prefetch_unit: RTL

- Instruction-fetch stage that sits directly upstream of the decode stage. It owns the program counter and issues one synchronous read per cycle to program memory.
- Returned instructions are buffered in a small prefetch queue, and the block drives the IF/ID pipeline register (instruction, PC+1, valid) into decode.
- It honours a hazard stall from the hazard detector and a PC redirect from the branch/jump select logic. On a redirect it squashes everything younger than the redirect.

---
 rtl/fetch_prefetch_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : Instruction fetch stage with PC, prefetch queue and IF/ID reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_prefetch_unit #(
   parameter int              AW    = 8,
   parameter int              IW    = 17,
   parameter int              DEPTH = 2,
   parameter logic [IW-1:0]   NOP   = {IW{1'b0}}
) (
   input  logic          clk,
   input  logic          reset,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic [IW-1:0] imem_data,
   input  logic          stall_i,
   input  logic          redirect_i,
   input  logic [AW-1:0] redirect_pc_i,
   output logic [IW-1:0] ir_o,
   output logic [AW-1:0] pc1_o,
   output logic          valid_o,
   output logic [AW-1:0] fetch_pc_o
);

   localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CW = c_PW + 1;

   logic [AW-1:0]   r_fetch_pc;
   logic [AW-1:0]   r_req_addr;
   logic            r_inflight;
   logic [c_CW-1:0] r_count;
   logic [c_PW-1:0] r_head;
   logic [c_PW-1:0] r_tail;
   logic [IW-1:0]   r_q_ir [DEPTH];
   logic [AW-1:0]   r_q_pc [DEPTH];
   logic [IW-1:0]   r_ir;
   logic [AW-1:0]   r_pc1;
   logic            r_valid;

   logic [c_CW-1:0] w_occ;
   logic            w_issue;
   logic [AW-1:0]   w_resp_pc;
   logic            w_resp_ok;
   logic            w_pop;
   logic            w_bypass;
   logic            w_push;

   // Occupancy counts queued entries plus the read still in flight, so the
   // queue can always absorb every response that has been requested.
   assign w_occ     = r_count + {{(c_CW-1){1'b0}}, r_inflight};
   assign w_issue   = (w_occ < c_CW'(DEPTH)) || redirect_i;
   assign imem_req  = reset && w_issue;
   assign imem_addr = redirect_i ? redirect_pc_i : r_fetch_pc;

   // A response landing in a redirect cycle belongs to the squashed path.
   assign w_resp_ok = r_inflight && !redirect_i;
   assign w_resp_pc = r_req_addr + AW'(1);
   assign w_pop     = !redirect_i && !stall_i && (r_count != '0);
   assign w_bypass  = !redirect_i && !stall_i && (r_count == '0) && w_resp_ok;
   assign w_push    = w_resp_ok && !w_bypass;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_fetch_pc <= '0;
         r_req_addr <= '0;
         r_inflight <= 1'b0;
         r_count    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_ir       <= NOP;
         r_pc1      <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_fetch_pc <= imem_addr + AW'(1);
            r_req_addr <= imem_addr;
         end

         if (redirect_i) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
         end else begin
            if (w_push) r_tail <= r_tail + c_PW'(1);
            if (w_pop)  r_head <= r_head + c_PW'(1);
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + c_CW'(1);
               2'b01:   r_count <= r_count - c_CW'(1);
               default: r_count <= r_count;
            endcase
         end

         if (redirect_i) begin
            r_ir    <= NOP;
            r_valid <= 1'b0;
         end else if (!stall_i) begin
            if (w_pop) begin
               r_ir    <= r_q_ir[r_head];
               r_pc1   <= r_q_pc[r_head];
               r_valid <= 1'b1;
            end else if (w_bypass) begin
               r_ir    <= imem_data;
               r_pc1   <= w_resp_pc;
               r_valid <= 1'b1;
            end else begin
               r_ir    <= NOP;
               r_valid <= 1'b0;
            end
         end
      end
   end

   // Storage needs no reset: entries are only read while the count says valid.
   always_ff @(posedge clk) begin
      if (reset && w_push) begin
         r_q_ir[r_tail] <= imem_data;
         r_q_pc[r_tail] <= w_resp_pc;
      end
   end

   assign ir_o       = r_ir;
   assign pc1_o      = r_pc1;
   assign valid_o    = r_valid;
   assign fetch_pc_o = r_fetch_pc;

endmodule

`default_nettype wire
